// File: rtl/rv32i_data_mem_responder_if.sv
// Data-memory request/response bundle between the core's load/store stage
// and the memory responder. Signal suffixes are from the responder's view.
interface rv32i_data_mem_responder_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [1:0]  req_op_i;
  logic [1:0]  req_size_i;
  logic        req_unsigned_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;

  modport slave (
    input  req_valid_i, req_op_i, req_size_i, req_unsigned_i,
    input  req_addr_i, req_wdata_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
  );

  modport master (
    output req_valid_i, req_op_i, req_size_i, req_unsigned_i,
    output req_addr_i, req_wdata_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
  );
endinterface

// File: rtl/rv32i_data_mem_responder.sv
// Word-organised data RAM answering one load/store/noop request at a time,
// with a fixed number of wait states before the single registered response.
module rv32i_data_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  rv32i_data_mem_responder_if.slave   bus
);

  localparam int         AW       = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_STORE = 2'b01;
  localparam logic [1:0] OP_NOOP  = 2'b11;

  localparam logic [1:0] SZ_BYTE  = 2'b00;
  localparam logic [1:0] SZ_HALF  = 2'b01;
  localparam logic [1:0] SZ_WORD  = 2'b10;
  localparam logic [1:0] SZ_RSVD  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic [1:0]  op_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        req_ready_q;
  logic        rsp_valid_q;
  logic [31:0] rsp_rdata_q;
  logic        rsp_err_q;

  logic [31:0] mem_q [DEPTH_WORDS];

  logic [AW-1:0] idx_d;
  logic [31:0]   rd_word_d;
  logic [7:0]    byte_d;
  logic [15:0]   half_d;
  logic [31:0]   ext_d;
  logic          err_d;
  logic          ok_d;
  logic          we_d;
  logic [3:0]    be_d;
  logic [31:0]   wword_d;
  logic [31:0]   rdata_d;
  logic          commit_d;

  assign bus.req_ready_o = req_ready_q;
  assign bus.rsp_valid_o = rsp_valid_q;
  assign bus.rsp_rdata_o = rsp_rdata_q;
  assign bus.rsp_err_o   = rsp_err_q;

  // Decode the latched request: fault checks, load extraction, store lane mask.
  always_comb begin
    idx_d     = addr_q[AW+1:2];
    rd_word_d = mem_q[idx_d];
    err_d     = 1'b0;
    ok_d      = 1'b0;
    ext_d     = 32'd0;
    be_d      = 4'b0000;
    wword_d   = 32'd0;
    rdata_d   = 32'd0;
    we_d      = 1'b0;
    commit_d  = (state_q == ST_WAIT) && (cnt_q == 4'd0);

    case (op_q)
      OP_LOAD, OP_STORE: begin
        if (size_q == SZ_RSVD) begin
          err_d = 1'b1;
        end else if ((size_q == SZ_HALF) && addr_q[0]) begin
          err_d = 1'b1;
        end else if ((size_q == SZ_WORD) && (addr_q[1:0] != 2'b00)) begin
          err_d = 1'b1;
        end else if ({2'b00, addr_q[31:2]} >= 32'(DEPTH_WORDS)) begin
          err_d = 1'b1;
        end else begin
          ok_d = 1'b1;
        end
      end
      OP_NOOP: begin
        err_d = 1'b0;
      end
      default: begin
        err_d = 1'b1;
      end
    endcase

    byte_d = rd_word_d[{addr_q[1:0], 3'b000} +: 8];
    half_d = rd_word_d[{addr_q[1], 4'b0000} +: 16];

    case (size_q)
      SZ_BYTE: begin
        ext_d   = {{24{byte_d[7] & ~uns_q}}, byte_d};
        be_d    = 4'b0001 << addr_q[1:0];
        wword_d = {4{wdata_q[7:0]}};
      end
      SZ_HALF: begin
        ext_d   = {{16{half_d[15] & ~uns_q}}, half_d};
        be_d    = addr_q[1] ? 4'b1100 : 4'b0011;
        wword_d = {2{wdata_q[15:0]}};
      end
      default: begin
        ext_d   = rd_word_d;
        be_d    = 4'b1111;
        wword_d = wdata_q;
      end
    endcase

    if (ok_d && (op_q == OP_LOAD)) begin
      rdata_d = ext_d;
    end else begin
      rdata_d = 32'd0;
    end

    if (ok_d && (op_q == OP_STORE)) begin
      we_d = 1'b1;
    end else begin
      we_d = 1'b0;
    end
  end

  // Byte-lane array write; a reset in the commit cycle suppresses the store.
  always_ff @(posedge clk) begin
    if (!reset && commit_d && we_d) begin
      for (int i = 0; i < 4; i++) begin
        if (be_d[i]) begin
          mem_q[idx_d][8*i +: 8] <= wword_d[8*i +: 8];
        end
      end
    end
  end

  // Request/wait/response sequencing with registered handshake outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      op_q        <= OP_NOOP;
      size_q      <= SZ_BYTE;
      uns_q       <= 1'b0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.req_valid_i && req_ready_q) begin
            op_q        <= bus.req_op_i;
            size_q      <= bus.req_size_i;
            uns_q       <= bus.req_unsigned_i;
            addr_q      <= bus.req_addr_i;
            wdata_q     <= bus.req_wdata_i;
            cnt_q       <= CNT_LOAD;
            req_ready_q <= 1'b0;
            state_q     <= ST_WAIT;
          end else begin
            req_ready_q <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (cnt_q == 4'd0) begin
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= rdata_d;
            rsp_err_q   <= err_d;
            state_q     <= ST_RESP;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ST_RESP: begin
          // Ready comes back one cycle after the handshake, never in it.
          if (bus.rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          req_ready_q <= 1'b1;
          rsp_valid_q <= 1'b0;
          rsp_rdata_q <= 32'd0;
          rsp_err_q   <= 1'b0;
        end
      endcase
    end
  end

endmodule
